// File: rtl/prog_run_ctrl.sv
// Run controller that sequences the single-cycle core through one program run.
// It holds the core in reset while the start PC loads. It then counts RUN
// cycles until halt, waits a drain window and reports done, or reports timeout
// if the cycle cap is reached first.
module prog_run_ctrl #(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int START0     = 0,
  parameter int START1     = 64,
  parameter int START2     = 128,
  parameter int START3     = 192,
  parameter int RST_CYCLES = 2,
  parameter int DRAIN      = 2,
  parameter int MAX_CYCLES = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             abort,
  input  logic             halt,
  output logic             core_rst,
  output logic             pc_load,
  output logic [PC_W-1:0]  start_pc,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_TMO
  } state_t;

  localparam logic [CNT_W-1:0] LP_HOLD_INIT  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_DRAIN_INIT = (DRAIN > 0) ? CNT_W'(DRAIN - 1) : '0;
  localparam logic [CNT_W-1:0] LP_MAX        = CNT_W'(MAX_CYCLES);

  state_t           r_state;
  logic             r_coreRst;
  logic             r_pcLoad;
  logic [PC_W-1:0]  r_startPc;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycleCount;
  logic [CNT_W-1:0] r_wait;

  state_t           w_nextState;
  logic             w_nextCoreRst;
  logic             w_nextPcLoad;
  logic [PC_W-1:0]  w_nextStartPc;
  logic             w_nextDone;
  logic             w_nextTimeout;
  logic [CNT_W-1:0] w_nextCycleCount;
  logic [CNT_W-1:0] w_nextWait;
  logic [CNT_W-1:0] w_countInc;

  function automatic logic [PC_W-1:0] pcFor(input logic [1:0] sel);
    case (sel)
      2'd0:    pcFor = PC_W'(START0);
      2'd1:    pcFor = PC_W'(START1);
      2'd2:    pcFor = PC_W'(START2);
      default: pcFor = PC_W'(START3);
    endcase
  endfunction

  assign w_countInc = r_cycleCount + 1'b1;

  // Next-state and next-output logic; outputs are registered, so each branch describes the values seen after the edge.
  always_comb begin
    w_nextState      = r_state;
    w_nextCoreRst    = r_coreRst;
    w_nextPcLoad     = r_pcLoad;
    w_nextStartPc    = r_startPc;
    w_nextDone       = r_done;
    w_nextTimeout    = r_timeout;
    w_nextCycleCount = r_cycleCount;
    w_nextWait       = r_wait;

    case (r_state)
      ST_IDLE, ST_DONE, ST_TMO: begin
        if (start) begin
          w_nextState      = ST_HOLD;
          w_nextCoreRst    = 1'b1;
          w_nextPcLoad     = 1'b1;
          w_nextStartPc    = pcFor(prog_sel);
          w_nextDone       = 1'b0;
          w_nextTimeout    = 1'b0;
          w_nextCycleCount = '0;
          w_nextWait       = LP_HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (r_wait == '0) begin
          w_nextState   = ST_RUN;
          w_nextCoreRst = 1'b0;
          w_nextPcLoad  = 1'b0;
        end else begin
          w_nextWait = r_wait - 1'b1;
        end
      end
      ST_RUN: begin
        w_nextCycleCount = w_countInc;
        if (halt) begin
          if (DRAIN == 0) begin
            w_nextState   = ST_DONE;
            w_nextCoreRst = 1'b1;
            w_nextDone    = 1'b1;
          end else begin
            w_nextState = ST_DRAIN;
            w_nextWait  = LP_DRAIN_INIT;
          end
        end else if (w_countInc == LP_MAX) begin
          w_nextState   = ST_TMO;
          w_nextCoreRst = 1'b1;
          w_nextTimeout = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_wait == '0) begin
          w_nextState   = ST_DONE;
          w_nextCoreRst = 1'b1;
          w_nextDone    = 1'b1;
        end else begin
          w_nextWait = r_wait - 1'b1;
        end
      end
      default: begin
        w_nextState   = ST_IDLE;
        w_nextCoreRst = 1'b1;
        w_nextPcLoad  = 1'b0;
      end
    endcase

    if (abort) begin
      w_nextState      = ST_IDLE;
      w_nextCoreRst    = 1'b1;
      w_nextPcLoad     = 1'b0;
      w_nextDone       = 1'b0;
      w_nextTimeout    = 1'b0;
      w_nextCycleCount = r_cycleCount;
      w_nextStartPc    = r_startPc;
      w_nextWait       = '0;
    end
  end

  // State and registered outputs, forced to idle values by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_coreRst    <= 1'b1;
      r_pcLoad     <= 1'b0;
      r_startPc    <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycleCount <= '0;
      r_wait       <= '0;
    end else begin
      r_state      <= w_nextState;
      r_coreRst    <= w_nextCoreRst;
      r_pcLoad     <= w_nextPcLoad;
      r_startPc    <= w_nextStartPc;
      r_done       <= w_nextDone;
      r_timeout    <= w_nextTimeout;
      r_cycleCount <= w_nextCycleCount;
      r_wait       <= w_nextWait;
    end
  end

  assign core_rst    = r_coreRst;
  assign pc_load     = r_pcLoad;
  assign start_pc    = r_startPc;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycleCount;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl with hand-computed expectations for the default parameters.
module tb_prog_run_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  progSel;
  logic        abort;
  logic        halt;
  logic        coreRst;
  logic        pcLoad;
  logic [9:0]  startPc;
  logic        done;
  logic        timeout;
  logic [15:0] cycleCount;

  int testCount = 0;
  int failCount = 0;

  prog_run_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_sel    (progSel),
    .abort       (abort),
    .halt        (halt),
    .core_rst    (coreRst),
    .pc_load     (pcLoad),
    .start_pc    (startPc),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycleCount)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expectation and records the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Sets all control inputs at once.
  task automatic applyStimulus(input logic s, input logic [1:0] sel, input logic h, input logic a);
    start   = s;
    progSel = sel;
    halt    = h;
    abort   = a;
  endtask

  // Advances n clock edges, leaving time 1 ns after the last edge for sampling.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Checks every output against a full expected set.
  task automatic checkAll(input string tag, input logic eRst, input logic eLoad, input logic [9:0] ePc,
                          input logic eDone, input logic eTmo, input logic [15:0] eCnt);
    checkOutput({tag, ".core_rst"}, 32'(coreRst), 32'(eRst));
    checkOutput({tag, ".pc_load"}, 32'(pcLoad), 32'(eLoad));
    checkOutput({tag, ".start_pc"}, 32'(startPc), 32'(ePc));
    checkOutput({tag, ".done"}, 32'(done), 32'(eDone));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(eTmo));
    checkOutput({tag, ".cycle_count"}, 32'(cycleCount), 32'(eCnt));
  endtask

  initial begin
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    stepCycles(2);
    checkAll("reset", 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    stepCycles(1);
    checkAll("idle", 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0);

    // Program 1: two HOLD cycles at PC 64, halt on RUN cycle 10, two drain cycles.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("hold1a", 1'b1, 1'b1, 10'd64, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("hold1b", 1'b1, 1'b1, 10'd64, 1'b0, 1'b0, 16'd0);
    stepCycles(1);
    checkAll("run1", 1'b0, 1'b0, 10'd64, 1'b0, 1'b0, 16'd0);
    stepCycles(9);
    checkOutput("run1.c9", 32'(cycleCount), 32'd9);
    applyStimulus(1'b0, 2'd3, 1'b1, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b0);
    checkAll("drain1a", 1'b0, 1'b0, 10'd64, 1'b0, 1'b0, 16'd10);
    stepCycles(1);
    checkAll("drain1b", 1'b0, 1'b0, 10'd64, 1'b0, 1'b0, 16'd10);
    stepCycles(1);
    checkAll("done1", 1'b1, 1'b0, 10'd64, 1'b1, 1'b0, 16'd10);
    applyStimulus(1'b0, 2'd3, 1'b1, 1'b0);
    stepCycles(2);
    checkAll("done1.halt", 1'b1, 1'b0, 10'd64, 1'b1, 1'b0, 16'd10);

    // Program 2 from DONE: restart, ignored start pulses in RUN, timeout at 500.
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("hold2", 1'b1, 1'b1, 10'd128, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    stepCycles(2);
    checkAll("run2", 1'b0, 1'b0, 10'd128, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 499; i++) begin
      applyStimulus((i >= 5 && i <= 7), 2'd1, 1'b0, 1'b0);
      stepCycles(1);
      if (i == 7) checkAll("run2.startIgnored", 1'b0, 1'b0, 10'd128, 1'b0, 1'b0, 16'd7);
    end
    checkAll("run2.c499", 1'b0, 1'b0, 10'd128, 1'b0, 1'b0, 16'd499);
    stepCycles(1);
    checkAll("tmo2", 1'b1, 1'b0, 10'd128, 1'b0, 1'b1, 16'd500);

    // Program 3 from TMO: halt exactly on RUN cycle 500 beats the cap.
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("hold3", 1'b1, 1'b1, 10'd192, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b0);
    stepCycles(2);
    stepCycles(499);
    checkOutput("run3.c499", 32'(cycleCount), 32'd499);
    applyStimulus(1'b0, 2'd3, 1'b1, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b0);
    checkAll("drain3", 1'b0, 1'b0, 10'd192, 1'b0, 1'b0, 16'd500);
    stepCycles(2);
    checkAll("done3", 1'b1, 1'b0, 10'd192, 1'b1, 1'b0, 16'd500);

    // Program 0: abort after 37 RUN cycles, abort beats a simultaneous start.
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("hold4", 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    stepCycles(2);
    stepCycles(37);
    checkOutput("run4.c37", 32'(cycleCount), 32'd37);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
    stepCycles(1);
    checkAll("abort4", 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd37);
    stepCycles(1);
    checkAll("abort4.hold", 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd37);

    // Program 2 again: start after abort drops, then reset mid-DRAIN between edges.
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("hold5", 1'b1, 1'b1, 10'd128, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    stepCycles(2);
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkAll("drain5", 1'b0, 1'b0, 10'd128, 1'b0, 1'b0, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    checkAll("asyncReset", 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0);
    stepCycles(1);
    reset = 1'b1;
    stepCycles(3);
    checkAll("postReset", 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Run controller that sequences the single-cycle core through one program execution.
- On a start request it latches the program select, holds the core in reset and loads the program's start PC. It then releases the core and counts cycles until the core raises halt.
- After halt it waits a drain window for late data-memory writes to settle, then reports done. A cycle cap reports timeout instead of hanging the bench.
- Sits between the top-level bench controls (start, prog_sel) and the core's reset/PC-load inputs.

Parameters:
- PC_W, 10, program counter width.
- CNT_W, 16, cycle counter width.
- START0, 0, start PC for prog_sel=0.
- START1, 64, start PC for prog_sel=1.
- START2, 128, start PC for prog_sel=2.
- START3, 192, start PC for prog_sel=3.
- RST_CYCLES, 2, cycles the core is held in reset with pc_load asserted (>=1).
- DRAIN, 2, cycles after halt before done (>=0).
- MAX_CYCLES, 500, RUN-state cycle cap (>=1, < 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled run request.
- prog_sel  in  2  program select, latched on accepted start.
- abort  in  1  return to IDLE from any state.
- halt  in  1  core halt indication.
- core_rst  out  1  active-high reset to core.
- pc_load  out  1  core loads start_pc this cycle.
- start_pc  out  PC_W  PC value for load.
- done  out  1  run finished normally, held until next run.
- timeout  out  1  run hit MAX_CYCLES, held until next run.
- cycle_count  out  CNT_W  RUN-state cycles of current/last run.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, core_rst=1, pc_load=0, start_pc=0, done=0, timeout=0, cycle_count=0, internal counters=0.
  - Leaving reset takes effect on the first rising edge with reset=1.
- All outputs are registered; values below are as seen after the transition edge.
- States: IDLE, HOLD, RUN, DRAIN, DONE, TMO.
- IDLE: core_rst=1, pc_load=0. On start=1: latch sel=prog_sel, clear cycle_count/done/timeout, load hold counter=RST_CYCLES-1, go HOLD.
- HOLD:
  - core_rst=1, pc_load=1, start_pc=START[sel].
  - Decrement the hold counter; at 0 go RUN with pc_load=0.
  - HOLD lasts exactly RST_CYCLES cycles.
  - start_pc keeps START[sel] until the next accepted start.
- RUN:
  - core_rst=0; cycle_count += 1 each cycle.
  - halt=1: go DRAIN, or DONE directly if DRAIN=0; cycle_count includes the halt cycle.
  - Else if cycle_count reaches MAX_CYCLES: go TMO.
  - halt and cap in the same cycle: halt wins.
- DRAIN: core_rst=0, cycle_count frozen, count DRAIN cycles, then DONE.
- DONE: done=1, core_rst=1 (core frozen, memory preserved).
- TMO: timeout=1, core_rst=1.
- Restart: in DONE/TMO, start=1 behaves as in IDLE. done/timeout drop on the edge entering HOLD; prog_sel is re-latched.
- Ignored inputs:
  - start in HOLD/RUN/DRAIN is ignored (no re-latch).
  - halt outside RUN is ignored.
  - prog_sel changes after acceptance are ignored.
- abort=1 in any state: next edge goes to IDLE with core_rst=1, pc_load=0, done=0, timeout=0. cycle_count is held for inspection.
  - abort and start in the same cycle: abort wins; start is not accepted until abort=0.
- Reset asserted mid-run forces the reset values immediately, without waiting for clk.
- done and timeout are never both 1.
- Exactly one pc_load pulse train per accepted start.

Test Plan:
- Reset then start=1 for one cycle with prog_sel=1 (RST_CYCLES=2):
  - core_rst=1 and pc_load=1 for 2 cycles with start_pc=64, then core_rst=0.
  - halt at RUN cycle 10 -> cycle_count=10; done=1 after 2 DRAIN cycles; core_rst=1.
- MAX_CYCLES=500, halt never asserted -> TMO after 500 RUN cycles: timeout=1, done=0, cycle_count=500.
- halt asserted on RUN cycle 500 (MAX_CYCLES=500) -> DRAIN then done=1, timeout=0.
- From DONE, start with prog_sel=2 -> done clears on HOLD entry, start_pc=128, cycle_count restarts at 0.
  - start pulses during RUN have no effect.
- abort mid-RUN at cycle 37 -> IDLE next edge, core_rst=1, cycle_count=37, done=0.
- reset=0 asserted mid-DRAIN, between clock edges -> all outputs take reset values before the next clk edge.
